// File: rtl/window_extrema_finder_if.sv
// rtl/window_extrema_finder_if.sv - sample stream and result bundle for the window extrema finder
interface window_extrema_finder_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 5
);
    logic              start;
    logic              valid;
    logic [DATA_W-1:0] numb;
    logic              in_ready;
    logic              busy;
    logic              done;
    logic              Q;
    logic [DATA_W-1:0] maxnumb;
    logic [DATA_W-1:0] minnumb;
    logic [IDX_W-1:0]  maxidx;

    modport master (
        output start, valid, numb,
        input  in_ready, busy, done, Q, maxnumb, minnumb, maxidx
    );

    modport slave (
        input  start, valid, numb,
        output in_ready, busy, done, Q, maxnumb, minnumb, maxidx
    );
endinterface

// File: rtl/window_extrema_finder.sv
// rtl/window_extrema_finder.sv - max/min/first-max-index over a window of WIN_LEN accepted samples
module window_extrema_finder #(
    parameter int DATA_W     = 8,
    parameter int WIN_LEN    = 20,
    parameter int SIGNED     = 0,
    parameter int CONTINUOUS = 0
) (
    input  logic                  CLK,
    input  logic                  RESETZ,
    window_extrema_finder_if.slave bus
);
    localparam int IDX_W = $clog2(WIN_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

    typedef enum logic {IDLE, ACC} state_t;

    state_t            state, state_n;
    logic [IDX_W-1:0]  count, count_n;
    logic [DATA_W-1:0] run_max, run_max_n;
    logic [DATA_W-1:0] run_min, run_min_n;
    logic [IDX_W-1:0]  run_idx, run_idx_n;
    logic [DATA_W-1:0] res_max, res_max_n;
    logic [DATA_W-1:0] res_min, res_min_n;
    logic [IDX_W-1:0]  res_idx, res_idx_n;
    logic              done_r, done_n;
    logic              q_r, q_n;

    // Candidate running values if the current sample is accepted
    logic [DATA_W-1:0] cand_max, cand_min;
    logic [IDX_W-1:0]  cand_idx;

    function automatic logic greater(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED != 0)
            return $signed(a) > $signed(b);
        else
            return a > b;
    endfunction

    always_comb begin
        cand_max = run_max;
        cand_min = run_min;
        cand_idx = run_idx;
        if (count == '0) begin
            cand_max = bus.numb;
            cand_min = bus.numb;
            cand_idx = '0;
        end else begin
            // Strict compares keep the earliest max index and the existing min on ties
            if (greater(bus.numb, run_max)) begin
                cand_max = bus.numb;
                cand_idx = count;
            end
            if (greater(run_min, bus.numb))
                cand_min = bus.numb;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        run_max_n = run_max;
        run_min_n = run_min;
        run_idx_n = run_idx;
        res_max_n = res_max;
        res_min_n = res_min;
        res_idx_n = res_idx;
        done_n    = 1'b0;
        q_n       = q_r;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = ACC;
                    count_n = '0;
                    q_n     = 1'b0;
                end
            end
            ACC: begin
                if (bus.start) begin
                    count_n = '0;
                    q_n     = 1'b0;
                end else if (bus.valid) begin
                    run_max_n = cand_max;
                    run_min_n = cand_min;
                    run_idx_n = cand_idx;
                    if (count == LAST_IDX) begin
                        res_max_n = cand_max;
                        res_min_n = cand_min;
                        res_idx_n = cand_idx;
                        done_n    = 1'b1;
                        q_n       = 1'b1;
                        count_n   = '0;
                        state_n   = (CONTINUOUS != 0) ? ACC : IDLE;
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETZ) begin
        if (!RESETZ) begin
            state   <= IDLE;
            count   <= '0;
            run_max <= '0;
            run_min <= '0;
            run_idx <= '0;
            res_max <= '0;
            res_min <= '0;
            res_idx <= '0;
            done_r  <= 1'b0;
            q_r     <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            run_max <= run_max_n;
            run_min <= run_min_n;
            run_idx <= run_idx_n;
            res_max <= res_max_n;
            res_min <= res_min_n;
            res_idx <= res_idx_n;
            done_r  <= done_n;
            q_r     <= q_n;
        end
    end

    assign bus.in_ready = (state == ACC);
    assign bus.busy     = (state == ACC);
    assign bus.done     = done_r;
    assign bus.Q        = q_r;
    assign bus.maxnumb  = res_max;
    assign bus.minnumb  = res_min;
    assign bus.maxidx   = res_idx;
endmodule

// File: tb/tb_window_extrema_finder.sv
// tb/tb_window_extrema_finder.sv - directed self-checking bench for window_extrema_finder
module tb_window_extrema_finder;
    logic CLK;
    logic RESETZ;
    int   total;
    int   bad;

    window_extrema_finder_if #(.DATA_W(8), .IDX_W(5)) if_def ();
    window_extrema_finder_if #(.DATA_W(8), .IDX_W(2)) if_sgn ();
    window_extrema_finder_if #(.DATA_W(8), .IDX_W(2)) if_cnt ();

    window_extrema_finder #(.DATA_W(8), .WIN_LEN(20), .SIGNED(0), .CONTINUOUS(0))
        u_def (.CLK(CLK), .RESETZ(RESETZ), .bus(if_def.slave));
    window_extrema_finder #(.DATA_W(8), .WIN_LEN(4), .SIGNED(1), .CONTINUOUS(0))
        u_sgn (.CLK(CLK), .RESETZ(RESETZ), .bus(if_sgn.slave));
    window_extrema_finder #(.DATA_W(8), .WIN_LEN(4), .SIGNED(0), .CONTINUOUS(1))
        u_cnt (.CLK(CLK), .RESETZ(RESETZ), .bus(if_cnt.slave));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] def_vec [20];
    logic [7:0] sgn_vec [4];
    logic [7:0] cnt_vec [8];
    int         done_seen;

    initial begin
        total = 0;
        bad   = 0;
        def_vec = '{8'd5, 8'd17, 8'd3, 8'd200, 8'd9, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90,
                    8'd100, 8'd1, 8'd110, 8'd120, 8'd130, 8'd140, 8'd150, 8'd160, 8'd170, 8'd180};
        sgn_vec = '{8'hFB, 8'hFE, 8'hF7, 8'hFE};
        cnt_vec = '{8'd1, 8'd9, 8'd2, 8'd3, 8'd8, 8'd4, 8'd0, 8'd5};

        if_def.start = 1'b0; if_def.valid = 1'b0; if_def.numb = '0;
        if_sgn.start = 1'b0; if_sgn.valid = 1'b0; if_sgn.numb = '0;
        if_cnt.start = 1'b0; if_cnt.valid = 1'b0; if_cnt.numb = '0;
        RESETZ = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 32'(if_def.in_ready), 32'd0);
        check("rst_busy",     32'(if_def.busy),     32'd0);
        check("rst_done",     32'(if_def.done),     32'd0);
        check("rst_q",        32'(if_def.Q),        32'd0);
        check("rst_max",      32'(if_def.maxnumb),  32'd0);
        check("rst_min",      32'(if_def.minnumb),  32'd0);
        check("rst_idx",      32'(if_def.maxidx),   32'd0);
        RESETZ = 1'b1;
        tick();

        // Default window of 20 unsigned samples
        if_def.start = 1'b1;
        tick();
        if_def.start = 1'b0;
        check("def_armed_ready", 32'(if_def.in_ready), 32'd1);
        for (int i = 0; i < 20; i++) begin
            if_def.valid = 1'b1;
            if_def.numb  = def_vec[i];
            tick();
            if (i == 18) check("def_no_early_done", 32'(if_def.done), 32'd0);
        end
        if_def.valid = 1'b0;
        check("def_done",     32'(if_def.done),     32'd1);
        check("def_max",      32'(if_def.maxnumb),  32'd200);
        check("def_idx",      32'(if_def.maxidx),   32'd3);
        check("def_min",      32'(if_def.minnumb),  32'd1);
        check("def_q",        32'(if_def.Q),        32'd1);
        check("def_in_ready", 32'(if_def.in_ready), 32'd0);
        tick();
        check("def_done_pulse", 32'(if_def.done), 32'd0);
        check("def_q_sticky",   32'(if_def.Q),    32'd1);

        // Signed window with a tied maximum
        if_sgn.start = 1'b1;
        tick();
        if_sgn.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if_sgn.valid = 1'b1;
            if_sgn.numb  = sgn_vec[i];
            tick();
        end
        if_sgn.valid = 1'b0;
        check("sgn_done", 32'(if_sgn.done),    32'd1);
        check("sgn_max",  32'(if_sgn.maxnumb), 32'h000000FE);
        check("sgn_idx",  32'(if_sgn.maxidx),  32'd1);
        check("sgn_min",  32'(if_sgn.minnumb), 32'h000000F7);
        tick();

        // Gapped samples, abort via start on the third, then a clean restart
        done_seen = 0;
        if_sgn.start = 1'b1;
        tick();
        if_sgn.start = 1'b0;
        if_sgn.valid = 1'b1; if_sgn.numb = 8'd10; tick();
        if_sgn.valid = 1'b0; tick();
        if_sgn.valid = 1'b1; if_sgn.numb = 8'd40; tick();
        if_sgn.valid = 1'b0; tick();
        if_sgn.start = 1'b1; if_sgn.valid = 1'b1; if_sgn.numb = 8'd40; tick();
        if_sgn.start = 1'b0;
        check("abt_q_cleared", 32'(if_sgn.Q),       32'd0);
        check("abt_max_hold",  32'(if_sgn.maxnumb), 32'h000000FE);
        check("abt_ready",     32'(if_sgn.in_ready), 32'd1);
        if_sgn.numb = 8'd7; tick();
        if (if_sgn.done) done_seen++;
        if_sgn.valid = 1'b0; tick();
        if (if_sgn.done) done_seen++;
        check("abt_no_done", 32'(done_seen), 32'd0);
        if_sgn.start = 1'b1;
        tick();
        if_sgn.start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            if_sgn.valid = 1'b1;
            if_sgn.numb  = 8'(i);
            tick();
            if_sgn.valid = 1'b0;
            if (i < 4) tick();
        end
        check("rst_win_done", 32'(if_sgn.done),    32'd1);
        check("rst_win_max",  32'(if_sgn.maxnumb), 32'd4);
        check("rst_win_idx",  32'(if_sgn.maxidx),  32'd3);
        check("rst_win_min",  32'(if_sgn.minnumb), 32'd1);
        tick();

        // Continuous back-to-back windows
        if_cnt.start = 1'b1;
        tick();
        if_cnt.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if_cnt.valid = 1'b1;
            if_cnt.numb  = cnt_vec[i];
            tick();
            check("cnt_ready", 32'(if_cnt.in_ready), 32'd1);
            if (i == 3) begin
                check("cnt_w0_done", 32'(if_cnt.done),    32'd1);
                check("cnt_w0_max",  32'(if_cnt.maxnumb), 32'd9);
                check("cnt_w0_idx",  32'(if_cnt.maxidx),  32'd1);
                check("cnt_w0_min",  32'(if_cnt.minnumb), 32'd1);
            end
            if (i == 4) begin
                check("cnt_gap_done", 32'(if_cnt.done),    32'd0);
                check("cnt_hold_max", 32'(if_cnt.maxnumb), 32'd9);
                check("cnt_q_keep",   32'(if_cnt.Q),       32'd1);
            end
        end
        if_cnt.valid = 1'b0;
        check("cnt_w1_done", 32'(if_cnt.done),    32'd1);
        check("cnt_w1_max",  32'(if_cnt.maxnumb), 32'd8);
        check("cnt_w1_idx",  32'(if_cnt.maxidx),  32'd0);
        check("cnt_w1_min",  32'(if_cnt.minnumb), 32'd0);
        tick();

        // Asynchronous reset mid-window
        if_sgn.start = 1'b1;
        tick();
        if_sgn.start = 1'b0;
        if_sgn.valid = 1'b1; if_sgn.numb = 8'd20; tick();
        if_sgn.numb = 8'd30; tick();
        if_sgn.valid = 1'b0;
        RESETZ = 1'b0;
        #2;
        check("arst_ready", 32'(if_sgn.in_ready), 32'd0);
        check("arst_max",   32'(if_sgn.maxnumb),  32'd0);
        check("arst_min",   32'(if_sgn.minnumb),  32'd0);
        check("arst_idx",   32'(if_sgn.maxidx),   32'd0);
        check("arst_q",     32'(if_sgn.Q),        32'd0);
        check("arst_def_max", 32'(if_def.maxnumb), 32'd0);
        tick();
        RESETZ = 1'b1;
        tick();

        // Valid without start is ignored in IDLE
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if_sgn.valid = 1'b1;
            if_sgn.numb  = 8'(50 + i);
            tick();
            if (if_sgn.done) done_seen++;
        end
        if_sgn.valid = 1'b0;
        tick();
        if (if_sgn.done) done_seen++;
        check("idle_no_done", 32'(done_seen),       32'd0);
        check("idle_max",     32'(if_sgn.maxnumb),  32'd0);
        check("idle_ready",   32'(if_sgn.in_ready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
